// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter (keyboard emulator).
// Queued bytes are sent as 11-bit device-to-host frames: start, 8 data bits LSB first, odd
// parity and stop. If the host inhibits the bus before the stop bit, the frame is aborted. The
// aborted byte is then resent ahead of the FIFO contents.
module ps2_device_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_CYCLES = 100,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          host_inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned TimerMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  // Timer only ever holds values up to TimerMax-1.
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StGap} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push;
  logic            pop;

  // Frame engine state
  state_e          state_q;
  logic [9:0]      shift_q;     // bits still to send after the one on ps2_data
  logic [3:0]      bit_cnt_q;
  logic [TimerW-1:0] timer_q;
  logic [7:0]      byte_q;      // byte of the current frame, kept for retransmission
  logic            retx_q;      // byte_q was aborted and must go out next
  logic            ps2_clk_q;
  logic            ps2_data_q;

  logic            start;
  logic [7:0]      start_byte;
  logic            abort;
  logic            phase_done;

  // Full FIFO refuses a push even when a pop happens in the same cycle.
  assign tx_ready   = (count_q != CntW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;

  assign start      = (state_q == StIdle) && !host_inhibit && (retx_q || (count_q != '0));
  assign start_byte = retx_q ? byte_q : mem_q[rd_ptr_q];
  assign pop        = start && !retx_q;

  // Inhibit aborts the frame at any bit except the stop bit.
  assign abort      = ((state_q == StHigh) || (state_q == StLow)) && host_inhibit &&
                      (bit_cnt_q != 4'd10);
  assign phase_done = (timer_q == TimerW'(CLK_DIV - 1));

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = (state_q != StIdle);

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // FIFO data array; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // Frame state machine with registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '1;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      byte_q     <= '0;
      retx_q     <= 1'b0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            byte_q     <= start_byte;
            retx_q     <= 1'b0;
            shift_q    <= {1'b1, ~^start_byte, start_byte};
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b0;
            state_q    <= StHigh;
          end
        end
        StHigh: begin
          if (abort) begin
            retx_q     <= 1'b1;
            timer_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            state_q    <= StGap;
          end else if (phase_done) begin
            timer_q    <= '0;
            ps2_clk_q  <= 1'b0;
            state_q    <= StLow;
          end else begin
            timer_q    <= timer_q + 1'b1;
          end
        end
        StLow: begin
          if (abort) begin
            retx_q     <= 1'b1;
            timer_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            state_q    <= StGap;
          end else if (phase_done) begin
            timer_q   <= '0;
            ps2_clk_q <= 1'b1;
            if (bit_cnt_q == 4'd10) begin
              ps2_data_q <= 1'b1;
              state_q    <= StGap;
            end else begin
              // Next bit appears together with the rising clock.
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              ps2_data_q <= shift_q[0];
              shift_q    <= {1'b1, shift_q[9:1]};
              state_q    <= StHigh;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StGap: begin
          if (timer_q == TimerW'(GAP_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a line monitor decodes frames and checks them against a scoreboard
// of accepted bytes, plus directed checks on reset, FIFO limits, inhibit abort and mid-frame reset.
module tb_ps2_device_tx;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned GapCycles = 10;
  localparam int unsigned FifoDepth = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       host_inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [3:0] fifo_count;

  always #5 clk = ~clk;

  ps2_device_tx #(
    .CLK_DIV   (ClkDiv),
    .GAP_CYCLES(GapCycles),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .host_inhibit(host_inhibit),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  int         mon_nbits = 0;
  int         mon_falls = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: decodes falling-edge samples into frames and checks phase lengths and gaps.
  initial begin : monitor
    logic       prev_clk;
    logic       armed;
    logic [10:0] fr;
    logic [7:0] exp_b;
    int         hi_cnt;
    int         lo_cnt;
    int         gap_cnt;
    prev_clk = 1'b1;
    armed    = 1'b0;
    fr       = '0;
    hi_cnt   = 0;
    lo_cnt   = 0;
    gap_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_nbits = 0;
        armed     = 1'b0;
        hi_cnt    = 0;
        lo_cnt    = 0;
      end else if (prev_clk && !ps2_clk) begin
        if (mon_nbits > 0) check_eq("high_phase", 32'(hi_cnt), 32'(ClkDiv));
        fr[mon_nbits] = ps2_data;
        mon_nbits++;
        mon_falls++;
        lo_cnt = 1;
        if (mon_nbits == 11) begin
          check_eq("frame_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            check_eq("frame_bits", 32'(fr), 32'({1'b1, ~^exp_b, exp_b, 1'b0}));
            check_eq("parity", 32'(fr[9]), 32'(~^exp_b));
          end
          mon_nbits = 0;
          armed     = (sb.size() != 0);
          gap_cnt   = 0;
        end
      end else if (!prev_clk && ps2_clk) begin
        check_eq("low_phase", 32'(lo_cnt), 32'(ClkDiv));
        hi_cnt = 1;
      end else if (ps2_clk) begin
        hi_cnt++;
        // Clock high for longer than a half-period mid-frame means the frame was abandoned.
        if (mon_nbits > 0 && hi_cnt > int'(ClkDiv)) begin
          mon_nbits = 0;
          armed     = 1'b0;
        end
      end else begin
        lo_cnt++;
      end
      if (!rst && armed && mon_nbits == 0 && ps2_clk) begin
        if (ps2_data) begin
          gap_cnt++;
        end else begin
          check_eq("b2b_gap", 32'(gap_cnt), 32'(GapCycles + 1));
          armed = 1'b0;
        end
      end
      prev_clk = rst ? 1'b1 : ps2_clk;
    end
  end

  // Called on a negedge; returns on the negedge after the byte is accepted.
  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
    check_eq("push_ready", 32'(tx_ready), 32'd1);
    if (tx_ready) sb.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits until all expected frames are out and the DUT is idle; counts busy cycles.
  task automatic drain(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0 && !busy) break;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check_eq("drain_sb", 32'(sb.size()), 32'd0);
    check_eq("drain_idle", 32'(busy), 32'd0);
  endtask

  // Waits for the high phase of frame bit n.
  task automatic wait_bit(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (mon_nbits == n && ps2_clk) break;
      @(negedge clk);
    end
    check_eq("reach_bit", 32'(mon_nbits), 32'(n));
  endtask

  initial begin : driver
    int bcyc;
    int falls0;
    rst          = 1'b1;
    tx_data      = '0;
    tx_valid     = 1'b0;
    host_inhibit = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_clk", 32'(ps2_clk), 32'd1);
    check_eq("rst_data", 32'(ps2_data), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, frame length and gap measured via busy
    push_byte(8'h1C);
    drain(bcyc);
    check_eq("busy_len", 32'(bcyc), 32'(22 * ClkDiv + GapCycles));

    // Back-to-back frames
    push_byte(8'hF0);
    push_byte(8'h1C);
    drain(bcyc);

    // Fill while inhibited; ninth push refused
    host_inhibit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tx_data  = 8'(8'h30 + i);
      tx_valid = 1'b1;
      check_eq((i < 8) ? "ready_not_full" : "ready_full", 32'(tx_ready), 32'(i < 8));
      if (tx_ready) sb.push_back(tx_data);
      @(negedge clk);
    end
    check_eq("full_count", 32'(fifo_count), 32'(FifoDepth));
    check_eq("full_ready", 32'(tx_ready), 32'd0);
    // Release with a push pending while full: pop happens, push is refused.
    tx_data      = 8'h99;
    host_inhibit = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("full_push_pop", 32'(fifo_count), 32'(FifoDepth - 1));
    drain(bcyc);

    // Abort at bit 4 of 0x55, then retransmit before 0x12
    push_byte(8'h55);
    push_byte(8'h12);
    check_eq("push_pop_same", 32'(fifo_count), 32'd1);
    wait_bit(4);
    host_inhibit = 1'b1;
    @(negedge clk);
    check_eq("abort_clk", 32'(ps2_clk), 32'd1);
    check_eq("abort_data", 32'(ps2_data), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd1);
    repeat (GapCycles + 5) @(negedge clk);
    check_eq("inhibit_idle", 32'(busy), 32'd0);
    check_eq("inhibit_count", 32'(fifo_count), 32'd1);
    check_eq("inhibit_lines", 32'({ps2_clk, ps2_data}), 32'd3);
    host_inhibit = 1'b0;
    drain(bcyc);

    // Reset mid-frame with three bytes queued
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    wait_bit(6);
    check_eq("queued_before_rst", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_eq("mid_rst_clk", 32'(ps2_clk), 32'd1);
    check_eq("mid_rst_data", 32'(ps2_data), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst    = 1'b0;
    falls0 = mon_falls;
    repeat (300) @(negedge clk);
    check_eq("no_falls_after_rst", 32'(mon_falls), 32'(falls0));
    check_eq("idle_after_rst", 32'(busy), 32'd0);

    // Parity corner bytes
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h01);
    drain(bcyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
